dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Data-memory responder on the far side of the CPU load/store path. It accepts lw/sw requests from the scpu datapath over a valid/ready handshake, models a configurable access latency, and holds a word-addressed RAM. It also holds one memory-mapped LED register that drives the board `result` display. The CPU stalls on `req_ready`/`resp_valid`; this block is the responder that completes each access.

Parameters:
- DEPTH, 64: RAM words; index = addr[7:2]; power of two, ≤ 64.
- BASE_ADDR, 32'h10010000: byte address of RAM word 0.
- LED_ADDR, 32'h10010100: byte address of the LED register.
- LATENCY, 2: cycles from request acceptance to response; must be ≥ 1.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  CPU presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store (sw), 0 = load (lw).
- req_addr  in  32  byte address, from ALU base+offset.
- req_wdata  in  32  store data, from rd2.
- resp_valid  out  1  response available.
- resp_ready  in  1  CPU consumes response.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  misaligned or unmapped address.
- led_out  out  32  LED register contents.

Behaviour:
- Clock and reset: one clock domain (clk). rst is asynchronous, active-high, and forces:
  - state = IDLE, so req_ready = 1 once rst deasserts;
  - resp_valid = 0, resp_rdata = 0, resp_err = 0, led_out = 0, latency counter = 0.
  - RAM contents are not reset.
- States: IDLE, WAIT, RESP. req_ready = (state == IDLE), combinational from state.
- IDLE:
  - Acceptance occurs on a posedge with req_valid & req_ready.
  - On acceptance, capture req_we, req_addr and req_wdata into internal registers, load counter = LATENCY-1, and go to WAIT.
  - Inputs are ignored after acceptance.
- WAIT:
  - While counter ≠ 0, decrement each cycle.
  - On the edge where counter == 0, perform the access using the captured values, register resp_rdata and resp_err, set resp_valid = 1, and go to RESP.
  - Accept at edge N gives resp_valid high after edge N+LATENCY.
- Address decode (on captured addr):
  - addr[1:0] ≠ 0 → err.
  - addr == LED_ADDR → LED register.
  - BASE_ADDR ≤ addr < BASE_ADDR + 4·DEPTH → RAM[addr[7:2]].
  - Anything else → err.
- Access rules:
  - Error: no state is modified; resp_rdata = 0, resp_err = 1.
  - Store: RAM word or led_out <= wdata; resp_rdata = 0.
  - Load: resp_rdata = RAM word or led_out.
  - Full 32-bit words only; no byte enables.
- RESP:
  - resp_valid, resp_rdata and resp_err hold stable until a posedge with resp_ready = 1.
  - On that edge: resp_valid = 0, resp_rdata = 0, resp_err = 0, go to IDLE.
  - A new request cannot be accepted on that same edge, because req_ready = 0 in RESP. Minimum back-to-back spacing is therefore LATENCY + 2 cycles.
- Reset mid-operation: any access not yet performed, i.e. reset before the WAIT→RESP edge, is abandoned with no RAM/LED write. A pending response is discarded.
- A store followed by a load to the same address returns the new data.
- Address boundaries: the last valid RAM word is BASE_ADDR + 4·DEPTH − 4; the next word address errors. There is no wrap-around of the RAM index.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then release → req_ready=1, resp_valid=0, led_out=0, resp_rdata=0.
- Store/load, LATENCY=2:
  - sw 0x12345678 to 0x10010004 accepted at edge N → resp_valid rises after N+2 with resp_err=0, resp_rdata=0.
  - Then lw 0x10010004 → resp_rdata=0x12345678.
- LED register: sw 0x000000A5 to 0x10010100 → led_out=0x000000A5 from edge N+2; lw of the same address returns 0x000000A5.
- Errors:
  - sw to 0x10010002 (misaligned) → resp_err=1, resp_rdata=0, RAM unchanged.
  - lw 0x10010200 (unmapped) → resp_err=1.
  - lw 0x100100FC (last RAM word) → resp_err=0.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid/rdata stable and req_ready=0 throughout; resp_ready=1 → IDLE next edge, next request accepted one cycle later.
- Reset mid-op: accept sw 0xDEADBEEF to 0x10010008, assert rst during WAIT → no response; subsequent lw 0x10010008 returns prior contents, not 0xDEADBEEF.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - lw/sw data-memory responder with latency model, word RAM and LED register
// One access at a time: IDLE accepts, WAIT counts down the latency, RESP holds the result.
module dmem_responder #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter logic [31:0] LED_ADDR  = 32'h1001_0100,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] led_out
);

  localparam int unsigned IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] led_q;
  logic [31:0] mem_q [DEPTH];

  logic [31:0]   offset;
  logic          aligned;
  logic          hit_led;
  logic          hit_ram;
  logic          acc_err;
  logic          do_access;
  logic          ram_we;
  logic [IW-1:0] ram_idx;
  logic [31:0]   acc_rdata;

  // Addresses below BASE_ADDR wrap to a huge offset and so fall outside the RAM window.
  assign offset    = addr_q - BASE_ADDR;
  assign aligned   = (addr_q[1:0] == 2'b00);
  assign hit_led   = aligned && (addr_q == LED_ADDR);
  assign hit_ram   = aligned && !hit_led && (offset < RAM_BYTES);
  assign ram_idx   = offset[IW+1:2];
  assign acc_err   = !(hit_led || hit_ram);
  assign do_access = (state_q == S_WAIT) && (cnt_q == '0);
  assign ram_we    = do_access && we_q && hit_ram;

  always_comb begin
    acc_rdata = 32'h0;
    if (!we_q) begin
      if (hit_led) begin
        acc_rdata = led_q;
      end else if (hit_ram) begin
        acc_rdata = mem_q[ram_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      led_q        <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= CNT_LOAD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= acc_err;
            resp_rdata_q <= acc_err ? 32'h0 : acc_rdata;
            if (we_q && hit_led) begin
              led_q <= wdata_q;
            end
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM contents survive reset; a reset before the access edge leaves state_q in IDLE so no write fires.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_idx] <= wdata_q;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign led_out    = led_q;

endmodule
